burst_line_master: RTL and testbench
====================================

# burst_line_master

Initiator for the burst RAM command interface. Converts single cache-line read/write requests from the cache controller into one burst command of BurstDataCount words. Serialises a write line onto wr_data, and reassembles read beats into a full line. Sits between the cache and the PSRAM controller, or its simulation model, and owns all command issue, calibration gating and read-timeout detection.

## Interface
- DataBitWidth, 64: RAM word width in bits; divisible by 8.
- AddressBitWidth, 4: RAM word-address width.
- BurstDataCount, 4: words per burst; power of two ≥ 2.
- TimeoutCycles, 64: maximum cycles from read command to first rd_data_valid.
- Derived widths:
  - LINE_BITS = DataBitWidth*BurstDataCount.
  - LINE_ADDR_BITS = AddressBitWidth-$clog2(BurstDataCount).

Ports (name, direction, width, meaning):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  client request present.
- req_write  in  1  0: read line, 1: write line.
- req_addr  in  LINE_ADDR_BITS  line address.
- req_wr_line  in  LINE_BITS  write data; word k = bits [k*DataBitWidth +: DataBitWidth].
- req_ready  out  1  request accepted when req_valid && req_ready.
- done  out  1  one-cycle pulse, transaction complete.
- error  out  1  one-cycle pulse coincident with done; read timed out or burst broken.
- rd_line  out  LINE_BITS  last read line; same word ordering as req_wr_line; held until the next read's done.
- cmd  out  1  0: read, 1: write.
- cmd_en  out  1  command valid; high exactly one cycle per transaction.
- addr  out  AddressBitWidth  word address = {line address, zeros}.
- wr_data  out  DataBitWidth  burst write word.
- data_mask  out  DataBitWidth/8  constant 0.
- rd_data  in  DataBitWidth  read beat.
- rd_data_valid  in  1  read beat valid.
- init_calib  in  1  RAM ready.
- ram_busy  in  1  RAM busy.

## Operation
- **States:** Calib, Idle, WriteBurst, ReadWait, ReadBurst, Done.
- **Calib:** req_ready=0. Go to Idle when init_calib=1.
- **Idle:** req_ready = init_calib && !ram_busy (combinational). On accept:
  - register the request;
  - next cycle drive cmd_en=1, cmd=req_write, addr={req_addr,0}, wr_data=word 0;
  - go to WriteBurst (write) or ReadWait (read).
- **WriteBurst:** drive wr_data = word 1, 2, …, N-1 on the N-1 cycles after the command cycle. After word N-1, go to Done.
- **ReadWait:** a timeout counter starts at 0 in the command cycle.
  - First rd_data_valid: store beat into word 0, go to ReadBurst.
  - Counter reaching TimeoutCycles first: set error, go to Done. rd_line is unchanged.
- **ReadBurst:** each rd_data_valid beat fills the next word slot. The beat counter is $clog2(N) bits and wraps naturally after beat N-1.
  - After beat N-1: commit the assembled buffer to rd_line, go to Done.
  - rd_data_valid low before N beats: set error, go to Done. rd_line is unchanged.
- **Done:** done=1 for one cycle; error=1 in the same cycle if flagged. Then go to Idle.
- rd_data_valid is ignored in Calib, Idle and WriteBurst.
- init_calib falling in Idle returns to Calib. During a transaction it is ignored until Done.
- req_* inputs are sampled only at accept; later changes have no effect.

## Timing
- **Reset values:** state Calib; all outputs 0 (req_ready, done, error, cmd, cmd_en, addr, wr_data, rd_line). data_mask is tied 0.
- **Write, accept in cycle T:** cmd_en in T+1 with word 0; word k in T+1+k; done in T+N+1.
- **Read, accept in cycle T:** cmd_en in T+1. With first beat in cycle B and N contiguous beats, done is in B+N and rd_line is valid from B+N.
- **Throughput:** the earliest next accept is the cycle after done, and only if ram_busy=0.
- **Reset mid-burst:** outputs clear immediately and the FSM goes to Calib. The RAM is not reset by this block. The next request waits for ram_busy=0.

## Structure
- Shared package burst_pkg holds:
  - CMD_READ=0, CMD_WRITE=1;
  - the state enum burst_master_state_e.
- Single module; no sub-module warranted.
- Datapath:
  - one LINE_BITS write-shift or index register;
  - one LINE_BITS read assembly buffer, separate from rd_line;
  - beat counter and timeout counter.

## Test plan
- **Calibration gate:** hold init_calib=0 for 10 cycles with req_valid=1. Required: req_ready=0 and no cmd_en. After init_calib=1, accept on the next cycle.
- **Write then read:** against a bench RAM model with 6-cycle read latency and N=4:
  - write line 0x...44_33_22_11 (words 0x11..0x44) to line address 2. Required: cmd_en once, addr=8, wr_data sequence 0x11, 0x22, 0x33, 0x44, done at T+5.
  - read the same line. Required: rd_line equal to the written line, error=0.
- **Back-to-back:** two writes with req_valid held continuously. Required: second accept only after done and ram_busy=0, and exactly two cmd_en pulses.
- **Read timeout:** the model never asserts rd_data_valid. Required: done and error together at command+64, rd_line unchanged, FSM in Idle.
- **Broken burst:** rd_data_valid drops after 2 beats. Required: done+error pulse, rd_line unchanged.
- **Reset mid-read:** assert rst during ReadBurst. Required: all outputs 0 asynchronously, and a subsequent read returns correct data after ram_busy clears.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared command codes and FSM state encoding for the burst RAM line master.
package burst_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_IDLE,
    ST_WRITE_BURST,
    ST_READ_WAIT,
    ST_READ_BURST,
    ST_DONE
  } burst_master_state_e;

endpackage

// File: rtl/burst_line_master.sv
// Turns one cache-line read/write into a single burst command: streams write words out,
// reassembles read beats into a line, and flags read timeouts or broken bursts.
module burst_line_master
  import burst_pkg::*;
#(
  parameter int DataBitWidth    = 64,
  parameter int AddressBitWidth = 4,
  parameter int BurstDataCount  = 4,
  parameter int TimeoutCycles   = 64,
  localparam int LINE_BITS      = DataBitWidth * BurstDataCount,
  localparam int LINE_ADDR_BITS = AddressBitWidth - $clog2(BurstDataCount)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic                        req_write,
  input  logic [LINE_ADDR_BITS-1:0]   req_addr,
  input  logic [LINE_BITS-1:0]        req_wr_line,
  output logic                        req_ready,
  output logic                        done,
  output logic                        error,
  output logic [LINE_BITS-1:0]        rd_line,
  output logic                        cmd,
  output logic                        cmd_en,
  output logic [AddressBitWidth-1:0]  addr,
  output logic [DataBitWidth-1:0]     wr_data,
  output logic [DataBitWidth/8-1:0]   data_mask,
  input  logic [DataBitWidth-1:0]     rd_data,
  input  logic                        rd_data_valid,
  input  logic                        init_calib,
  input  logic                        ram_busy
);

  localparam int BEAT_BITS = $clog2(BurstDataCount);
  localparam int TMO_BITS  = $clog2(TimeoutCycles + 1);

  burst_master_state_e    state;
  logic [LINE_BITS-1:0]   wr_shift;
  logic [LINE_BITS-1:0]   rd_buf;
  logic [LINE_BITS-1:0]   asm_line;
  logic [BEAT_BITS-1:0]   beat;
  logic [TMO_BITS-1:0]    tmo;

  assign data_mask = '0;
  assign req_ready = (state == ST_IDLE) && init_calib && !ram_busy;

  // Read buffer with the current beat dropped into its slot; feeds both rd_buf and rd_line.
  always_comb begin
    asm_line = rd_buf;
    asm_line[int'(beat)*DataBitWidth +: DataBitWidth] = rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CALIB;
      done     <= 1'b0;
      error    <= 1'b0;
      rd_line  <= '0;
      cmd      <= CMD_READ;
      cmd_en   <= 1'b0;
      addr     <= '0;
      wr_data  <= '0;
      wr_shift <= '0;
      rd_buf   <= '0;
      beat     <= '0;
      tmo      <= '0;
    end else begin
      cmd_en <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      case (state)
        ST_CALIB: begin
          if (init_calib) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!init_calib) begin
            state <= ST_CALIB;
          end else if (req_valid && req_ready) begin
            cmd_en   <= 1'b1;
            cmd      <= req_write;
            addr     <= {req_addr, {BEAT_BITS{1'b0}}};
            wr_data  <= req_wr_line[DataBitWidth-1:0];
            wr_shift <= req_wr_line >> DataBitWidth;
            tmo      <= '0;
            if (req_write == CMD_WRITE) begin
              beat  <= BEAT_BITS'(1);
              state <= ST_WRITE_BURST;
            end else begin
              beat  <= '0;
              state <= ST_READ_WAIT;
            end
          end
        end
        ST_WRITE_BURST: begin
          // beat wraps to zero once word N-1 has been put on wr_data
          if (beat == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wr_data  <= wr_shift[DataBitWidth-1:0];
            wr_shift <= wr_shift >> DataBitWidth;
            beat     <= beat + 1'b1;
          end
        end
        ST_READ_WAIT: begin
          if (rd_data_valid) begin
            rd_buf <= asm_line;
            beat   <= beat + 1'b1;
            state  <= ST_READ_BURST;
          end else if (tmo == TMO_BITS'(TimeoutCycles - 1)) begin
            done  <= 1'b1;
            error <= 1'b1;
            state <= ST_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_READ_BURST: begin
          if (rd_data_valid) begin
            rd_buf <= asm_line;
            beat   <= beat + 1'b1;
            if (beat == BEAT_BITS'(BurstDataCount - 1)) begin
              rd_line <= asm_line;
              done    <= 1'b1;
              state   <= ST_DONE;
            end
          end else begin
            done  <= 1'b1;
            error <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_CALIB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_master.sv
// Randomised scoreboard bench for burst_line_master with a word-level RAM model.
module tb_burst_line_master;

  localparam int DW   = 64;
  localparam int AW   = 4;
  localparam int N    = 4;
  localparam int TMO  = 64;
  localparam int LAT  = 6;
  localparam int LINE = DW * N;
  localparam int LAB  = AW - $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_write = 1'b0;
  logic [LAB-1:0]  req_addr = '0;
  logic [LINE-1:0] req_wr_line = '0;
  logic            req_ready, done, error, cmd, cmd_en;
  logic [LINE-1:0] rd_line;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] data_mask;
  logic [DW-1:0]   rd_data = '0;
  logic            rd_data_valid = 1'b0;
  logic            init_calib = 1'b0;
  logic            ram_busy = 1'b0;

  burst_line_master #(
    .DataBitWidth(DW), .AddressBitWidth(AW), .BurstDataCount(N), .TimeoutCycles(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wr_line(req_wr_line), .req_ready(req_ready),
    .done(done), .error(error), .rd_line(rd_line),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .init_calib(init_calib), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              write;
    int              la;
    logic [LINE-1:0] line;
    logic [LINE-1:0] rd_line;
    bit              err;
    int              done_off;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   cur_active = 0, in_flight = 0, idle_chk = 0;
  int   acc_cyc = 0, cmd_cyc = 0, wbeat = 0, n_cmd = 0;
  int   n_cmp = 0, n_bad = 0;

  logic [LINE-1:0] ref_line [1<<LAB];
  logic [LINE-1:0] ref_rd_line;
  int rd_mode = 0, rd_k = 0;

  task automatic check(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [LINE-1:0] rand_line();
    logic [LINE-1:0] l;
    for (int j = 0; j < LINE/32; j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  // RAM model: acts just after each rising edge; mode 0 normal, 1 silent, 2 stops after rd_k beats.
  logic [DW-1:0] mem [1<<AW];
  logic [AW-1:0] w_addr = '0, r_addr = '0;
  int w_left = 0, r_start = 0, r_cnt = 0, busy_until = -1;
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    forever begin
      @(posedge clk); #1;
      rd_data_valid = 1'b0;
      if (w_left > 0) begin
        mem[w_addr] = wr_data;
        w_addr = w_addr + 1'b1;
        w_left--;
      end
      if (cmd_en) begin
        if (cmd) begin
          mem[addr] = wr_data;
          w_addr = addr + 1'b1;
          w_left = N - 1;
          busy_until = cyc + N + 1;
        end else begin
          r_addr = addr;
          r_start = cyc + LAT;
          r_cnt = (rd_mode == 0) ? N : (rd_mode == 1) ? 0 : rd_k;
          busy_until = cyc + LAT + N + 1;
        end
      end
      if (cyc >= r_start && cyc < r_start + r_cnt) begin
        rd_data_valid = 1'b1;
        rd_data = mem[r_addr + AW'(cyc - r_start)];
      end
      ram_busy = (cyc <= busy_until);
    end
  end

  // Monitor: pops an expectation at each command, follows its write beats, checks its completion.
  always @(negedge clk) begin
    if (rst) begin
      cur_active = 0; in_flight = 0; wbeat = 0; idle_chk = 0;
    end else begin
      if (idle_chk) begin
        check("idle_after_done", LINE'(req_ready), LINE'(init_calib && !ram_busy));
        idle_chk = 0;
      end
      if (req_valid && req_ready) begin
        check("accept_after_done", LINE'(in_flight), LINE'(1'b0));
        check("accept_ram_free", LINE'(ram_busy), LINE'(1'b0));
        acc_cyc = cyc;
        in_flight = 1;
      end
      if (cmd_en) begin
        n_cmd++;
        check("cmd_expected", LINE'(exp_q.size() > 0), LINE'(1'b1));
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          cur_active = 1;
          cmd_cyc = cyc;
          check("cmd_dir", LINE'(cmd), LINE'(cur.write));
          check("cmd_addr", LINE'(addr), LINE'(cur.la * N));
          check("cmd_cycle", LINE'(cyc), LINE'(acc_cyc + 1));
          if (cur.write) begin
            check("wr_word0", LINE'(wr_data), LINE'(cur.line[DW-1:0]));
            wbeat = 1;
          end
        end
      end else if (wbeat > 0) begin
        check("wr_word", LINE'(wr_data), LINE'(cur.line[wbeat*DW +: DW]));
        wbeat++;
        if (wbeat == N) wbeat = 0;
      end
      if (done) begin
        check("done_expected", LINE'(cur_active), LINE'(1'b1));
        if (cur_active) begin
          check("done_cycle", LINE'(cyc), LINE'(cmd_cyc + cur.done_off));
          check("error_flag", LINE'(error), LINE'(cur.err));
          check("rd_line", rd_line, cur.rd_line);
        end
        cur_active = 0; in_flight = 0; idle_chk = 1;
      end else if (error) begin
        check("error_without_done", LINE'(error), LINE'(1'b0));
      end
    end
  end

  // Reference: a line-addressed memory plus the last successfully read line.
  task automatic present(input bit w, input int la, input logic [LINE-1:0] line,
                         input int mode, input int k);
    txn_t t;
    t.write = w; t.la = la; t.line = line; t.err = 0; t.done_off = N; t.rd_line = ref_rd_line;
    if (w) begin
      ref_line[la] = line;
    end else if (mode == 0) begin
      ref_rd_line = ref_line[la];
      t.rd_line = ref_rd_line;
      t.done_off = LAT + N;
    end else if (mode == 1) begin
      t.err = 1;
      t.done_off = TMO;
    end else begin
      t.err = 1;
      t.done_off = LAT + k + 1;
    end
    exp_q.push_back(t);
    rd_mode = mode; rd_k = k;
    req_valid = 1'b1; req_write = w; req_addr = LAB'(la); req_wr_line = line;
  endtask

  task automatic wait_accept(output int acyc);
    bit seen;
    seen = 0;
    acyc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin seen = 1; acyc = cyc; end
    end
    check("accept_seen", LINE'(seen), LINE'(1'b1));
    @(posedge clk); #2;
  endtask

  // Drop the request and scramble the request fields; they must not matter after accept.
  task automatic drop();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr = LAB'($urandom);
    req_wr_line = rand_line();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !cur_active && !in_flight;
    end
    check("txn_completed", LINE'(ok), LINE'(1'b1));
    if (!ok) begin exp_q.delete(); cur_active = 0; in_flight = 0; end
    @(posedge clk); #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, x, c0, m, k, la;
    bit w, seen;
    logic [LINE-1:0] l;
    for (int i = 0; i < (1<<LAB); i++) ref_line[i] = '0;
    ref_rd_line = '0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", LINE'(req_ready), '0);
    check("rst_done", LINE'(done), '0);
    check("rst_error", LINE'(error), '0);
    check("rst_cmd", LINE'(cmd), '0);
    check("rst_cmd_en", LINE'(cmd_en), '0);
    check("rst_addr", LINE'(addr), '0);
    check("rst_wr_data", LINE'(wr_data), '0);
    check("rst_rd_line", rd_line, '0);
    check("rst_data_mask", LINE'(data_mask), '0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Calibration gate with the known write to line 2 pending
    l = {64'h44, 64'h33, 64'h22, 64'h11};
    present(1, 2, l, 0, 0);
    repeat (10) begin
      @(negedge clk);
      check("calib_req_ready", LINE'(req_ready), '0);
      check("calib_cmd_en", LINE'(cmd_en), '0);
    end
    @(posedge clk); #2;
    init_calib = 1'b1;
    x = cyc;
    wait_accept(a);
    check("calib_accept_cycle", LINE'(a), LINE'(x + 1));
    drop(); wait_idle();

    present(0, 2, '0, 0, 0);
    wait_accept(a); drop(); wait_idle();

    // Back-to-back writes with req_valid held high
    c0 = n_cmd;
    present(1, 1, rand_line(), 0, 0);
    wait_accept(a);
    present(1, 3, rand_line(), 0, 0);
    wait_accept(a);
    drop(); wait_idle();
    check("b2b_cmd_count", LINE'(n_cmd - c0), LINE'(2));

    present(0, 1, '0, 1, 0);
    wait_accept(a); drop(); wait_idle();

    present(0, 3, '0, 2, 2);
    wait_accept(a); drop(); wait_idle();

    // Reset in the middle of a read burst
    present(0, 2, '0, 0, 0);
    wait_accept(a); drop();
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = rd_data_valid;
    end
    check("first_beat_seen", LINE'(seen), LINE'(1'b1));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_req_ready", LINE'(req_ready), '0);
    check("arst_done", LINE'(done), '0);
    check("arst_error", LINE'(error), '0);
    check("arst_cmd", LINE'(cmd), '0);
    check("arst_cmd_en", LINE'(cmd_en), '0);
    check("arst_addr", LINE'(addr), '0);
    check("arst_wr_data", LINE'(wr_data), '0);
    check("arst_rd_line", rd_line, '0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    ref_rd_line = '0;
    present(0, 2, '0, 0, 0);
    wait_accept(a); drop(); wait_idle();

    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      m = 0; k = 0;
      if (!w) begin
        m = $urandom_range(0, 7);
        if (m <= 5) m = 0;
        else if (m == 6) begin m = 2; k = $urandom_range(1, N - 1); end
        else m = 1;
      end
      la = $urandom_range(0, (1<<LAB) - 1);
      present(w, la, rand_line(), m, k);
      wait_accept(a); drop(); wait_idle();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
